pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: width, 32, bit width of PC, targets, memory address and retire counter.
REQ-002 Parameter: RESET_VEC, 0, PC value loaded on reset.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 Port: clk  input  1  rising-edge clock for all state.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: start  input  1  leave IDLE or HALTED and begin fetching.
REQ-007 Port: halt  input  1  stop after the current instruction retires.
REQ-008 Port: stall  input  1  hold the current instruction in EXEC.
REQ-009 Port: jump  input  1  take jump_target as next PC.
REQ-010 Port: jump_target  input  width  jump destination (word address).
REQ-011 Port: branch_taken  input  1  take branch_target as next PC.
REQ-012 Port: branch_target  input  width  branch destination (word address).
REQ-013 Port: imem_ack  input  1  instruction memory has returned data for imem_addr.
REQ-014 Port: imem_req  output  1  fetch request to instruction memory.
REQ-015 Port: imem_addr  output  width  fetch address, always equal to pc.
REQ-016 Port: instr_valid  output  1  fetched instruction is present and executing.
REQ-017 Port: pc  output  width  current program counter (registered).
REQ-018 Port: pc_plus1  output  width  pc + 1 modulo 2^width (combinational).
REQ-019 Port: retire_count  output  width  number of instructions retired since reset.
REQ-020 Port: state  output  2  encoded FSM state: IDLE=0, FETCH=1, EXEC=2, HALTED=3.

Function
REQ-021 The FSM SHALL have four states: IDLE, FETCH, EXEC and HALTED.
REQ-022 IDLE: start=1 SHALL move the FSM to FETCH on the next edge; all other inputs are ignored.
REQ-023 FETCH: imem_req SHALL be 1 (Moore output); imem_ack=1 SHALL move the FSM to EXEC; imem_ack=0 SHALL keep it in FETCH with pc unchanged.
REQ-024 EXEC: instr_valid SHALL be 1 (Moore output); imem_req SHALL be 0.
REQ-025 EXEC with stall=1 SHALL stay in EXEC with pc and retire_count unchanged; halt, jump and branch_taken are ignored that cycle.
REQ-026 EXEC with stall=0 SHALL retire the instruction: increment retire_count by 1 and load pc with the next-PC value.
REQ-027 Next-PC priority SHALL be: jump_target if jump=1, else branch_target if branch_taken=1, else pc_plus1.
REQ-028 On retire, next state SHALL be HALTED if halt=1, else FETCH.
REQ-029 HALTED: start=1 SHALL move the FSM to FETCH with pc unchanged; otherwise the FSM stays in HALTED.
REQ-030 Arithmetic SHALL wrap modulo 2^width: pc all-ones + 1 = 0, and retire_count all-ones + 1 = 0.
REQ-031 imem_ack outside FETCH SHALL be ignored.
REQ-032 jump, branch_taken, stall and halt outside EXEC SHALL be ignored.
REQ-033 Fetch latency SHALL be at least 1 cycle in FETCH plus 1 cycle in EXEC, giving a minimum of 2 cycles per instruction.

Reset
REQ-034 reset=1 SHALL, on the next edge and from any state, set pc=RESET_VEC, retire_count=0 and state=IDLE, overriding all other inputs.
REQ-035 After reset: imem_req=0, instr_valid=0, imem_addr=RESET_VEC, pc_plus1=RESET_VEC+1.
REQ-036 Reset asserted during FETCH or EXEC SHALL abandon the operation: no retire occurs, and imem_req and instr_valid are 0 from the first post-reset cycle.

Verification
REQ-037 Reset, start, ack every FETCH, no branches, 4 instructions -> pc goes 0,1,2,3,4; retire_count=4; state alternates 1,2.
REQ-038 In EXEC at pc=5, jump=1 with jump_target=0x40 and branch_taken=1 with branch_target=0x80 -> pc=0x40 (jump wins), retire_count+1, state=FETCH.
REQ-039 stall=1 for 3 cycles in EXEC at pc=7 -> pc stays 7, instr_valid stays 1 for 4 cycles, retire_count increments exactly once, on release.
REQ-040 imem_ack withheld 5 cycles -> imem_req stays 1 and imem_addr stays constant for 5 cycles, then EXEC follows.
REQ-041 pc=0xFFFFFFFF, retire with no branch -> pc=0; halt=1 at retire -> state=HALTED; start -> FETCH at imem_addr=0.
REQ-042 reset asserted in EXEC with stall=0 and jump=1 -> pc=RESET_VEC, retire_count=0, state=IDLE, instr_valid=0 next cycle.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for a simple fetch/execute loop.
// One instruction moves through FETCH (request until acked) and EXEC
// (execute until not stalled). Retiring the instruction in EXEC loads the
// next PC and bumps the retire counter. The FSM state is exported for
// observation.
//
// Handshake: in FETCH, imem_req is held high and imem_addr (== pc) stays
// stable until a rising edge that samples imem_ack=1. That edge completes
// the fetch, and the FSM enters EXEC. imem_ack is ignored in every other
// state.
module pc_sequencer #(
  parameter int                width     = 32,
  parameter logic [width-1:0]  RESET_VEC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt,
  input  logic             stall,
  input  logic             jump,
  input  logic [width-1:0] jump_target,
  input  logic             branch_taken,
  input  logic [width-1:0] branch_target,
  input  logic             imem_ack,
  output logic             imem_req,
  output logic [width-1:0] imem_addr,
  output logic             instr_valid,
  output logic [width-1:0] pc,
  output logic [width-1:0] pc_plus1,
  output logic [width-1:0] retire_count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_EXEC   = 2'd2,
    S_HALTED = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [width-1:0] pc_q, pc_d;
  logic [width-1:0] retire_q, retire_d;
  logic [width-1:0] pc_inc;

  // Incremented PC wraps naturally at the register width.
  always_comb begin
    pc_inc = pc_q + {{(width-1){1'b0}}, 1'b1};
  end

  // State, PC and retire counter registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_VEC;
      retire_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      retire_q <= retire_d;
    end
  end

  // Next-state logic, next-PC selection and Moore outputs.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    retire_d    = retire_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) state_d = S_EXEC;
      end
      S_EXEC: begin
        instr_valid = 1'b1;
        if (!stall) begin
          // Jump beats branch, and branch beats fall-through.
          if (jump)              pc_d = jump_target;
          else if (branch_taken) pc_d = branch_target;
          else                   pc_d = pc_inc;
          retire_d = retire_q + {{(width-1){1'b0}}, 1'b1};
          state_d  = halt ? S_HALTED : S_FETCH;
        end
      end
      S_HALTED: begin
        if (start) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output aliases of registered state.
  always_comb begin
    pc           = pc_q;
    imem_addr    = pc_q;
    pc_plus1     = pc_inc;
    retire_count = retire_q;
    state        = state_q;
  end

endmodule
